// File: rtl/seq_multiword_addsub.sv
// Multi-word adder/subtractor: one 32-bit limb per clock, LSB limb first,
// carry chained between limbs through a single flop.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start, ready=1
// RUN   | processing limb idx_q, one limb per cycle
// DONE  | result valid, done=1 and ready=1 for one cycle
module seq_multiword_addsub #(
  parameter int LIMBS = 2,
  localparam int W = 32 * LIMBS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         ready,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] y,
  output logic         cout,
  output logic         ovf,
  output logic         done
);

  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  y_q, y_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [31:0]   a_limb;
  logic [31:0]   b_limb;
  logic [32:0]   sum;
  logic          last_limb;
  logic          carry_into_msb;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Single 32-bit add; b_q is already inverted for subtract.
  always_comb begin
    a_limb         = a_q[32*idx_q +: 32];
    b_limb         = b_q[32*idx_q +: 32];
    sum            = {1'b0, a_limb} + {1'b0, b_limb} + {32'd0, carry_q};
    last_limb      = (idx_q == IW'(LIMBS - 1));
    carry_into_msb = a_limb[31] ^ b_limb[31] ^ sum[31];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    y_d     = y_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        y_d[32*idx_q +: 32] = sum[31:0];
        carry_d             = sum[32];
        if (last_limb) begin
          cout_d  = sum[32];
          ovf_d   = carry_into_msb ^ sum[32];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        // A start here chains straight into the next operation.
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign y     = y_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign ready = (state_q != RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiword_addsub.sv
// Bench for seq_multiword_addsub: LIMBS=1, 2 and 4 instances checked against
// a plain-arithmetic reference model.
module tb_seq_multiword_addsub;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         start1 = 0, sub1 = 0, cin1 = 0;
  logic [31:0]  a1 = '0, b1 = '0, y1;
  logic         ready1, cout1, ovf1, done1;

  logic         start2 = 0, sub2 = 0, cin2 = 0;
  logic [63:0]  a2 = '0, b2 = '0, y2;
  logic         ready2, cout2, ovf2, done2;

  logic         start4 = 0, sub4 = 0, cin4 = 0;
  logic [127:0] a4 = '0, b4 = '0, y4;
  logic         ready4, cout4, ovf4, done4;

  seq_multiword_addsub #(.LIMBS(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .ready(ready1), .sub(sub1),
    .a(a1), .b(b1), .cin(cin1), .y(y1), .cout(cout1), .ovf(ovf1), .done(done1));
  seq_multiword_addsub #(.LIMBS(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .ready(ready2), .sub(sub2),
    .a(a2), .b(b2), .cin(cin2), .y(y2), .cout(cout2), .ovf(ovf2), .done(done2));
  seq_multiword_addsub #(.LIMBS(4)) u_l4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .ready(ready4), .sub(sub4),
    .a(a4), .b(b4), .cin(cin4), .y(y4), .cout(cout4), .ovf(ovf4), .done(done4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on W bits, overflow from operand/result signs.
  task automatic ref_calc(input int limbs, input logic [127:0] a, input logic [127:0] b,
                          input logic s, input logic c,
                          output logic [127:0] y, output logic co, output logic ov);
    int w;
    logic [129:0] mask, bb, t;
    logic sa, sb, sy;
    w    = 32 * limbs;
    mask = (130'd1 << w) - 130'd1;
    bb   = s ? (~{2'b00, b} & mask) : ({2'b00, b} & mask);
    t    = ({2'b00, a} & mask) + bb + {129'd0, c ^ s};
    y    = t[127:0] & mask[127:0];
    co   = t[w];
    sa   = a[w-1];
    sb   = bb[w-1];
    sy   = y[w-1];
    ov   = (sa == sb) && (sy != sa);
  endtask

  task automatic drive(input int sel, input logic [127:0] a, input logic [127:0] b,
                       input logic s, input logic c, input logic st);
    case (sel)
      1: begin a1 = a[31:0]; b1 = b[31:0]; sub1 = s; cin1 = c; start1 = st; end
      2: begin a2 = a[63:0]; b2 = b[63:0]; sub2 = s; cin2 = c; start2 = st; end
      default: begin a4 = a; b4 = b; sub4 = s; cin4 = c; start4 = st; end
    endcase
  endtask

  function automatic logic [127:0] get_y(input int sel);
    case (sel)
      1: return {96'd0, y1};
      2: return {64'd0, y2};
      default: return y4;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      1: return done1;
      2: return done2;
      default: return done4;
    endcase
  endfunction

  function automatic logic get_cout(input int sel);
    case (sel)
      1: return cout1;
      2: return cout2;
      default: return cout4;
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      1: return ovf1;
      2: return ovf2;
      default: return ovf4;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      1: return ready1;
      2: return ready2;
      default: return ready4;
    endcase
  endfunction

  // One operation from idle: accept, wait for done, check latency/result/pulse width.
  task automatic do_op(input int sel, input logic [127:0] a, input logic [127:0] b,
                       input logic s, input logic c, input string tag);
    logic [127:0] ey;
    logic eco, eov;
    int lat;
    ref_calc(sel, a, b, s, c, ey, eco, eov);
    @(negedge clk);
    chk({tag, " ready_before"}, {127'd0, get_ready(sel)}, 128'd1);
    drive(sel, a, b, s, c, 1'b1);
    @(posedge clk);
    #1;
    drive(sel, ~a, ~b, ~s, ~c, 1'b0);
    lat = -1;
    for (int k = 1; k <= sel + 4; k++) begin
      @(posedge clk);
      #1;
      if (get_done(sel)) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 128'(lat), 128'(sel));
    chk({tag, " y"}, get_y(sel), ey);
    chk({tag, " cout"}, {127'd0, get_cout(sel)}, {127'd0, eco});
    chk({tag, " ovf"}, {127'd0, get_ovf(sel)}, {127'd0, eov});
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, {127'd0, get_done(sel)}, 128'd0);
    chk({tag, " y_hold"}, get_y(sel), ey);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic s;
    logic c;
  } op_t;

  initial begin
    op_t q[$];
    op_t o;
    logic [127:0] ey;
    logic eco, eov;
    int last_done, cyc, n_done;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst y4", y4, 128'd0);
    chk("rst cout4", {127'd0, cout4}, 128'd0);
    chk("rst ovf4", {127'd0, ovf4}, 128'd0);
    chk("rst done4", {127'd0, done4}, 128'd0);
    chk("rst ready4", {127'd0, ready4}, 128'd1);
    chk("rst ready1", {127'd0, ready1}, 128'd1);
    @(negedge clk);
    reset_n = 1'b1;

    do_op(1, 128'h67503B12, 128'hCD84DA1F, 1'b0, 1'b0, "l1_plan");
    do_op(2, 128'h00000000_FFFFFFFF, 128'h1, 1'b0, 1'b0, "l2_carry");
    do_op(2, 128'h0, 128'h1, 1'b1, 1'b0, "l2_sub_borrow");
    do_op(2, 128'h5, 128'h5, 1'b1, 1'b1, "l2_sub_cin");
    do_op(2, 128'h7FFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0, "l2_ovf_pos");
    do_op(2, 128'h80000000_00000000, 128'h80000000_00000000, 1'b0, 1'b0, "l2_ovf_neg");

    for (int i = 0; i < 6; i++) begin
      do_op(1, rnd128(), rnd128(), 1'($urandom()), 1'($urandom()), "l1_rand");
      do_op(2, rnd128(), rnd128(), 1'($urandom()), 1'($urandom()), "l2_rand");
      do_op(4, rnd128(), rnd128(), 1'($urandom()), 1'($urandom()), "l4_rand");
    end

    // Back-to-back on LIMBS=4 with start held high and operands changing every cycle.
    last_done = -1;
    n_done = 0;
    for (cyc = 0; cyc < 42; cyc++) begin
      @(negedge clk);
      o.a = rnd128(); o.b = rnd128(); o.s = 1'($urandom()); o.c = 1'($urandom());
      drive(4, o.a, o.b, o.s, o.c, 1'b1);
      if (ready4) q.push_back(o);
      @(posedge clk);
      #1;
      if (done4) begin
        n_done++;
        if (q.size() == 0) begin
          chk("b2b unexpected_done", 128'd1, 128'd0);
        end else begin
          o = q.pop_front();
          ref_calc(4, o.a, o.b, o.s, o.c, ey, eco, eov);
          chk("b2b y", y4, ey);
          chk("b2b cout", {127'd0, cout4}, {127'd0, eco});
          chk("b2b ovf", {127'd0, ovf4}, {127'd0, eov});
        end
        if (last_done >= 0) chk("b2b spacing", 128'(cyc - last_done), 128'd5);
        last_done = cyc;
      end
    end
    @(negedge clk);
    drive(4, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        n_done++;
        o = q.pop_front();
        ref_calc(4, o.a, o.b, o.s, o.c, ey, eco, eov);
        chk("b2b drain y", y4, ey);
      end
    end
    chk("b2b queue_empty", 128'(q.size()), 128'd0);
    chk("b2b done_count", 128'(n_done >= 8), 128'd1);
    repeat (3) @(posedge clk);

    // Reset while LIMBS=4 is processing limb 2.
    @(negedge clk);
    drive(4, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(4, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort running", {127'd0, ready4}, 128'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort y", y4, 128'd0);
    chk("abort cout", {127'd0, cout4}, 128'd0);
    chk("abort ovf", {127'd0, ovf4}, 128'd0);
    chk("abort ready", {127'd0, ready4}, 128'd1);
    chk("abort done", {127'd0, done4}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done4) n_done++;
    end
    chk("abort no_done", 128'(n_done), 128'd0);
    do_op(4, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
          1'b1, 1'b0, "l4_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
